// File: rtl/matrix_stream_out_pkg.sv
// matrix_pkg: constants, FSM state type and element addressing shared by the
// matrix memory/writer side and the streaming readout.
//   ELEM_W, ROWS, COLS : matrix geometry
//   MAT_W              : packed matrix width, derived from the geometry
//   state_t            : readout FSM states
//   elem_offset(r, c)  : bit offset of elem(r,c) inside the packed matrix
package matrix_pkg;

    localparam int ELEM_W = 21;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int MAT_W  = ROWS * COLS * ELEM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [8:0] elem_offset(input logic [1:0] r, input logic [1:0] c);
        return 9'((32'(r) * COLS + 32'(c)) * ELEM_W);
    endfunction

endpackage

// File: rtl/matrix_stream_out_if.sv
// Element stream from the matrix readout to its consumer.
//   out_valid/out_ready : handshake, transfer when both high at a rising edge
//   out_data            : element value
//   out_row/out_col     : element coordinates
//   out_last            : marks the final element of the matrix
// master = readout side, slave = consumer side.
interface matrix_stream_out_if;
    import matrix_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );

endinterface

// File: rtl/matrix_stream_out_elem_select.sv
// matrix_elem_select: combinational pick of one element out of a packed matrix.
//   mat  : packed matrix (elem(r,c) at elem_offset(r,c))
//   row  : element row
//   col  : element column
//   elem : selected element
module matrix_elem_select
    import matrix_pkg::*;
(
    input  logic [MAT_W-1:0]  mat,
    input  logic [1:0]        row,
    input  logic [1:0]        col,
    output logic [ELEM_W-1:0] elem
);

    assign elem = mat[elem_offset(row, col) +: ELEM_W];

endmodule

// File: rtl/matrix_stream_out.sv
// matrix_stream_out: snapshots a packed 4x4 matrix on start and streams it
// out one element per transfer, row-major or column-major.
//   CLK, reset : clock and synchronous active-high reset
//   start      : begin a readout (only honoured in IDLE)
//   transpose  : captured with start, 1 selects column-major order
//   matrix     : packed matrix from memory
//   out_if     : element stream (master side)
//   busy       : readout in progress (SEND or DONE)
//   done       : one-cycle pulse after the final transfer
//
// state | meaning
// IDLE  | waiting for start, stream outputs idle
// SEND  | presenting element counter, advancing on each transfer
// DONE  | final element taken, done pulse, back to IDLE next cycle
module matrix_stream_out
    import matrix_pkg::*;
(
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic               transpose,
    input  logic [MAT_W-1:0]   matrix,
    matrix_stream_out_if.master out_if,
    output logic               busy,
    output logic               done
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [MAT_W-1:0]  snap_q, snap_d;
    logic              load_out;
    logic [ELEM_W-1:0] data_q;
    logic [1:0]        row_q, col_q;

    logic [MAT_W-1:0]  sel_src;
    logic              sel_mode;
    logic [1:0]        sel_row, sel_col;
    logic [ELEM_W-1:0] sel_elem;
    logic              xfer;

    assign xfer = (state_q == SEND) && out_if.out_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        snap_d   = snap_q;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEND;
                    snap_d   = matrix;
                    mode_d   = transpose;
                    cnt_d    = 4'd0;
                    load_out = 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (cnt_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        cnt_d    = cnt_q + 4'd1;
                        load_out = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The output register is loaded with the element for cnt_d, so on start
    // it must come from the live matrix (the snapshot is being written the
    // same edge); afterwards it always comes from the snapshot.
    assign sel_src  = (state_q == IDLE) ? matrix : snap_q;
    assign sel_mode = (state_q == IDLE) ? transpose : mode_q;
    assign sel_row  = sel_mode ? cnt_d[1:0] : cnt_d[3:2];
    assign sel_col  = sel_mode ? cnt_d[3:2] : cnt_d[1:0];

    matrix_elem_select u_elem_select (
        .mat  (sel_src),
        .row  (sel_row),
        .col  (sel_col),
        .elem (sel_elem)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mode_q  <= 1'b0;
            snap_q  <= '0;
            data_q  <= '0;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            snap_q  <= snap_d;
            if (load_out) begin
                data_q <= sel_elem;
                row_q  <= sel_row;
                col_q  <= sel_col;
            end
        end
    end

    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_data  = data_q;
    assign out_if.out_row   = row_q;
    assign out_if.out_col   = col_q;
    assign out_if.out_last  = (state_q == SEND) && (cnt_q == 4'd15);
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);

endmodule

// File: tb/tb_matrix_stream_out.sv
module tb_matrix_stream_out;
    import matrix_pkg::*;

    logic             CLK = 1'b0;
    logic             reset;
    logic             start;
    logic             transpose;
    logic [MAT_W-1:0] matrix;
    logic             busy;
    logic             done;

    matrix_stream_out_if bus ();

    matrix_stream_out dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .transpose (transpose),
        .matrix    (matrix),
        .out_if    (bus.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ELEM_W-1:0] m [4][4];
    logic [ELEM_W-1:0] got [16];

    typedef struct {
        string             name;
        bit                tr;
        int                stall_pct;
        int                kind;
        logic [ELEM_W-1:0] exp_first;
        logic [ELEM_W-1:0] exp_beat4;
        logic [ELEM_W-1:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MAT_W-1:0] pack_m();
        logic [MAT_W-1:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[(r*4+c)*ELEM_W +: ELEM_W] = m[r][c];
        return v;
    endfunction

    task automatic fill_m(input int kind, input int base);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (kind == 0) m[r][c] = ELEM_W'(r*16 + c + base);
                else           m[r][c] = (r == 3 && c == 3) ? 21'h100001 : 21'h0;
            end
        matrix = pack_m();
    endtask

    // Drives one readout from IDLE. Expected beats come from the tb matrix
    // copy taken at start: in order k, row-major visits (k/4, k%4), column-major
    // visits (k%4, k/4).
    task automatic run_stream(input bit tr, input int pct, input int mut_beat,
                              input int start_beat, input int stop_after,
                              output int beats, output int cycles);
        logic [ELEM_W-1:0] exp_d [16];
        int                exp_r [16];
        int                exp_c [16];
        logic [ELEM_W-1:0] hold_d;
        logic [1:0]        hold_r, hold_c;
        logic              hold_l;
        bit                stalled, rdy;
        for (int k = 0; k < 16; k++) begin
            exp_r[k] = tr ? k % 4 : k / 4;
            exp_c[k] = tr ? k / 4 : k % 4;
            exp_d[k] = m[exp_r[k]][exp_c[k]];
        end
        start = 1'b1;
        transpose = tr;
        bus.out_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        transpose = 1'b0;
        chk("start_valid", 32'(bus.out_valid), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        beats = 0;
        cycles = 0;
        stalled = 1'b0;
        hold_d = '0; hold_r = '0; hold_c = '0; hold_l = 1'b0;
        while (beats < 16 && beats < stop_after && cycles < 400) begin
            if (bus.out_valid !== 1'b1) begin
                chk("valid_during_send", 32'(bus.out_valid), 32'd1);
                break;
            end
            if (stalled) begin
                chk("stall_hold_data", 32'(bus.out_data), 32'(hold_d));
                chk("stall_hold_rc", {bus.out_row, bus.out_col}, {hold_r, hold_c});
                chk("stall_hold_last", 32'(bus.out_last), 32'(hold_l));
            end
            start = (beats == start_beat);
            if (beats == mut_beat) matrix = {MAT_W{1'b1}};
            rdy = ($urandom_range(99) >= pct);
            bus.out_ready = rdy;
            if (rdy) begin
                chk("beat_data", 32'(bus.out_data), 32'(exp_d[beats]));
                chk("beat_row", 32'(bus.out_row), 32'(exp_r[beats]));
                chk("beat_col", 32'(bus.out_col), 32'(exp_c[beats]));
                chk("beat_last", 32'(bus.out_last), (beats == 15) ? 32'd1 : 32'd0);
                got[beats] = bus.out_data;
                beats++;
                stalled = 1'b0;
            end else begin
                hold_d = bus.out_data; hold_r = bus.out_row;
                hold_c = bus.out_col;  hold_l = bus.out_last;
                stalled = 1'b1;
            end
            cycles++;
            @(negedge CLK);
        end
        bus.out_ready = 1'b0;
        start = 1'b0;
        if (stop_after >= 16) begin
            chk("beat_count", 32'(beats), 32'd16);
            chk("done_valid", 32'(bus.out_valid), 32'd0);
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_busy", 32'(busy), 32'd1);
            @(negedge CLK);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, cycles;
        vecs[0] = '{"row_b2b",     1'b0, 0,  0, 21'd0, 21'd16, 21'd51};
        vecs[1] = '{"col_b2b",     1'b1, 0,  0, 21'd0, 21'd1,  21'd51};
        vecs[2] = '{"row_stall",   1'b0, 50, 0, 21'd0, 21'd16, 21'd51};
        vecs[3] = '{"col_stall",   1'b1, 40, 0, 21'd0, 21'd1,  21'd51};
        vecs[4] = '{"msb_lsb_row", 1'b0, 0,  1, 21'd0, 21'd0,  21'h100001};
        vecs[5] = '{"msb_lsb_col", 1'b1, 30, 1, 21'd0, 21'd0,  21'h100001};

        reset = 1'b1;
        start = 1'b0;
        transpose = 1'b0;
        bus.out_ready = 1'b0;
        fill_m(0, 0);
        repeat (3) @(negedge CLK);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_rc", {bus.out_row, bus.out_col}, 32'd0);
        reset = 1'b0;
        // ready asserted while idle must not matter
        bus.out_ready = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            fill_m(vecs[i].kind, 0);
            run_stream(vecs[i].tr, vecs[i].stall_pct, -1, -1, 16, beats, cycles);
            chk({vecs[i].name, "_first"}, 32'(got[0]), 32'(vecs[i].exp_first));
            chk({vecs[i].name, "_beat4"}, 32'(got[4]), 32'(vecs[i].exp_beat4));
            chk({vecs[i].name, "_last"}, 32'(got[15]), 32'(vecs[i].exp_last));
            if (vecs[i].stall_pct == 0)
                chk({vecs[i].name, "_cycles"}, 32'(cycles), 32'd16);
            repeat (2) @(negedge CLK);
        end

        // matrix overwritten and start re-pulsed mid-stream
        fill_m(0, 0);
        run_stream(1'b0, 20, 2, 5, 16, beats, cycles);
        chk("snap_last", 32'(got[15]), 32'd51);
        repeat (3) @(negedge CLK);
        chk("second_start_ignored", 32'(bus.out_valid), 32'd0);

        // reset after beat 7, then fresh start with a new matrix
        fill_m(0, 0);
        run_stream(1'b0, 0, -1, -1, 8, beats, cycles);
        chk("pre_reset_beats", 32'(beats), 32'd8);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_data", 32'(bus.out_data), 32'd0);
        fill_m(0, 100);
        run_stream(1'b0, 10, -1, -1, 16, beats, cycles);
        chk("after_rst_first", 32'(got[0]), 32'd100);
        chk("after_rst_last", 32'(got[15]), 32'd151);

        // start and reset on the same edge
        @(negedge CLK);
        reset = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        start = 1'b0;
        @(negedge CLK);
        chk("rst_beats_start_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_beats_start_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
